// File: rtl/response_control_router_pkg.sv
// Shared types for the PSL response router: raw response, tag-table line, routed entry, FSM states.
// Also holds the PSL response-code decode and the cmd_type -> channel mapping.
package response_control_router_pkg;

  localparam int PSL_TAG_W  = 8;
  localparam int CMD_TYPE_W = 3;
  localparam int CREDIT_W   = 9;

  typedef logic [CMD_TYPE_W-1:0] cmd_type_t;
  typedef logic [7:0]            psl_response_t;

  localparam cmd_type_t CMD_READ     = 3'd0;
  localparam cmd_type_t CMD_WRITE    = 3'd1;
  localparam cmd_type_t CMD_WED      = 3'd2;
  localparam cmd_type_t CMD_RESTART  = 3'd3;
  localparam cmd_type_t CMD_PREFETCH = 3'd4;

  localparam psl_response_t RESP_DONE    = 8'h00;
  localparam psl_response_t RESP_AERROR  = 8'h01;
  localparam psl_response_t RESP_DERROR  = 8'h03;
  localparam psl_response_t RESP_FAULT   = 8'h07;
  localparam psl_response_t RESP_FAILED  = 8'h08;
  localparam psl_response_t RESP_CONTEXT = 8'h0B;

  typedef struct packed {
    logic                 valid;
    logic [PSL_TAG_W-1:0] tag;
    logic                 tag_parity;
    psl_response_t        response;
    logic [CREDIT_W-1:0]  credits;
  } ResponseInterface;

  typedef struct packed {
    cmd_type_t            cmd_type;
    logic [PSL_TAG_W-1:0] tag;
  } CommandTagLine;

  typedef struct packed {
    logic                valid;
    CommandTagLine       cmd;
    psl_response_t       response;
    logic [CREDIT_W-1:0] response_credits;
  } ResponseControlLine;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } RESP_ROUTER_STATE;

  // One-hot error class; bit 5 catches every non-DONE code not listed explicitly.
  function automatic logic [5:0] cmd_response_error_type(input psl_response_t r);
    logic [5:0] e;
    case (r)
      RESP_DONE:    e = 6'b000000;
      RESP_AERROR:  e = 6'b000001;
      RESP_DERROR:  e = 6'b000010;
      RESP_FAULT:   e = 6'b000100;
      RESP_FAILED:  e = 6'b001000;
      RESP_CONTEXT: e = 6'b010000;
      default:      e = 6'b100000;
    endcase
    return e;
  endfunction

  function automatic int unsigned resp_chan_index(input cmd_type_t t);
    return int'(t);
  endfunction

endpackage

// File: rtl/response_control_router_if.sv
// PSL response side and per-channel consumer handshakes of the response router.
interface response_control_router_if
  import response_control_router_pkg::*;
#(
  parameter int NUM_CHANNELS = 5
) ();

  ResponseInterface        response;
  CommandTagLine           response_tag_id_in;
  logic [NUM_CHANNELS-1:0] chan_ready_in;
  logic [NUM_CHANNELS-1:0] chan_valid_out;
  ResponseControlLine      chan_response_out [NUM_CHANNELS];

  modport slave (
    input  response, response_tag_id_in, chan_ready_in,
    output chan_valid_out, chan_response_out
  );

  modport master (
    output response, response_tag_id_in, chan_ready_in,
    input  chan_valid_out, chan_response_out
  );

endinterface

// File: rtl/response_control_router_fifo.sv
// Per-channel synchronous FIFO with ready/valid head, plus the shared XOR-reduce parity helper.
// A push on a full FIFO is accepted only when the head pops in the same cycle.
module response_channel_fifo
  import response_control_router_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic               i_push,
  input  ResponseControlLine i_data,
  input  logic               i_ready,
  output logic               o_valid,
  output ResponseControlLine o_data,
  output logic               o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  ResponseControlLine r_mem [DEPTH];

  logic w_full;
  logic w_pop;
  logic w_write;

  assign o_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_pop      = o_valid && i_ready;
  assign w_write    = i_push && (!w_full || w_pop);
  assign o_overflow = i_push && w_full && !w_pop;
  assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (w_write) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

module parity #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] i_data,
  output logic            o_odd
);

  assign o_odd = ^i_data;

endmodule

// File: rtl/response_control_router.sv
// Latches PSL responses, decodes cmd_type and routes them into per-channel FIFOs with error pulses.
// Per-channel push and drop statistics exist only with RESPONSE_CONTROL_ROUTER_STATS_EN defined.
//   state  | meaning
//   IDLE   | disabled, responses ignored
//   ACTIVE | responses accepted into the pipeline
//   DRAIN  | no new responses; waits for pipeline and FIFOs to empty
module response_control_router
  import response_control_router_pkg::*;
#(
  parameter int NUM_CHANNELS = 5,
  parameter int FIFO_DEPTH   = 16,
  parameter int TAG_W        = PSL_TAG_W
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled_in,
  response_control_router_if.slave  rsp_if,
  output logic [8:0]                response_error,
  output logic                      drain_done,
  output logic [1:0]                state_out
`ifdef RESPONSE_CONTROL_ROUTER_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][31:0] chan_count_out,
  output logic [31:0]                   drop_count_out
`endif
);

  RESP_ROUTER_STATE r_state;

  logic                 r_s1_valid;
  logic [PSL_TAG_W-1:0] r_s1_tag;
  logic                 r_s1_tag_parity;
  psl_response_t        r_s1_response;
  logic [CREDIT_W-1:0]  r_s1_credits;

  logic                r_s2_valid;
  CommandTagLine       r_s2_cmd;
  psl_response_t       r_s2_response;
  logic [CREDIT_W-1:0] r_s2_credits;
  logic                r_s2_parity_err;

  logic                    w_tag_odd;
  logic                    w_unknown;
  logic                    w_all_empty;
  logic [NUM_CHANNELS-1:0] w_push;
  logic [NUM_CHANNELS-1:0] w_overflow;
  logic [NUM_CHANNELS-1:0] w_valid;
  ResponseControlLine      w_head [NUM_CHANNELS];
  ResponseControlLine      w_entry;

  parity #(.BITS(TAG_W)) u_tag_parity (
    .i_data (r_s1_tag[TAG_W-1:0]),
    .o_odd  (w_tag_odd)
  );

  assign w_unknown   = r_s2_valid &&
                       (resp_chan_index(r_s2_cmd.cmd_type) >= unsigned'(NUM_CHANNELS));
  assign w_all_empty = ~|w_valid;
  assign state_out   = r_state;

  always_comb begin
    w_entry                  = '0;
    w_entry.valid            = 1'b1;
    w_entry.cmd              = r_s2_cmd;
    w_entry.response         = r_s2_response;
    w_entry.response_credits = r_s2_credits;
  end

  // Two-stage pipeline; tag-table lookup arrives one cycle after the response and its tag is overridden.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid      <= 1'b0;
      r_s1_tag        <= '0;
      r_s1_tag_parity <= 1'b0;
      r_s1_response   <= '0;
      r_s1_credits    <= '0;
      r_s2_valid      <= 1'b0;
      r_s2_cmd        <= '0;
      r_s2_response   <= '0;
      r_s2_credits    <= '0;
      r_s2_parity_err <= 1'b0;
      response_error  <= '0;
    end else begin
      r_s1_valid      <= rsp_if.response.valid && (r_state == ACTIVE);
      r_s1_tag        <= rsp_if.response.tag;
      r_s1_tag_parity <= rsp_if.response.tag_parity;
      r_s1_response   <= rsp_if.response.response;
      r_s1_credits    <= rsp_if.response.credits;
      r_s2_valid        <= r_s1_valid;
      r_s2_cmd.cmd_type <= rsp_if.response_tag_id_in.cmd_type;
      r_s2_cmd.tag      <= r_s1_tag;
      r_s2_response     <= r_s1_response;
      r_s2_credits      <= r_s1_credits;
      r_s2_parity_err   <= w_tag_odd ^ r_s1_tag_parity;
      response_error <= {|w_overflow,
                         w_unknown,
                         r_s2_valid & r_s2_parity_err,
                         r_s2_valid ? cmd_response_error_type(r_s2_response) : 6'd0};
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign w_push[c] = r_s2_valid && (resp_chan_index(r_s2_cmd.cmd_type) == unsigned'(c));
    assign rsp_if.chan_response_out[c] = w_head[c];

    response_channel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock      (clock),
      .rstn       (rstn),
      .i_push     (w_push[c]),
      .i_data     (w_entry),
      .i_ready    (rsp_if.chan_ready_in[c]),
      .o_valid    (w_valid[c]),
      .o_data     (w_head[c]),
      .o_overflow (w_overflow[c])
    );
  end

  assign rsp_if.chan_valid_out = w_valid;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (r_state)
        IDLE:   if (enabled_in) r_state <= ACTIVE;
        ACTIVE: if (!enabled_in) r_state <= DRAIN;
        DRAIN: begin
          if (enabled_in) begin
            r_state <= ACTIVE;
          end else if (w_all_empty && !r_s1_valid && !r_s2_valid) begin
            r_state    <= IDLE;
            drain_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RESPONSE_CONTROL_ROUTER_STATS_EN
  logic [NUM_CHANNELS-1:0][31:0] r_chan_count;
  logic [31:0]                   r_drop_count;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_chan_count <= '0;
      r_drop_count <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_push[c] && !w_overflow[c] && (r_chan_count[c] != 32'hFFFF_FFFF))
          r_chan_count[c] <= r_chan_count[c] + 32'd1;
      end
      if ((w_unknown || (|w_overflow)) && (r_drop_count != 32'hFFFF_FFFF))
        r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign chan_count_out = r_chan_count;
  assign drop_count_out = r_drop_count;
`endif

endmodule
